// File: rtl/alarm_sequencer.sv
// Alarm sequencer for a 12-hour timekeeper. It watches the live time for the
// programmed alarm time and runs the ring, snooze, dismiss and auto-timeout sequence.
module alarm_sequencer #(
  parameter int unsigned SNOOZE_MIN = 9,
  parameter int unsigned MAX_SNOOZE = 3,
  parameter int unsigned RING_MIN   = 10
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_min_tick,
  input  logic [5:0] i_cur_min,
  input  logic [3:0] i_cur_hr,
  input  logic       i_cur_pm,
  input  logic [5:0] i_alarm_min,
  input  logic [3:0] i_alarm_hr,
  input  logic       i_alarm_pm,
  input  logic       i_alarm_en,
  input  logic       i_snooze,
  input  logic       i_dismiss,
  output logic       o_alarm_sound,
  output logic [1:0] o_state,
  output logic [2:0] o_snoozes_left
);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StArmed    = 2'd1,
    StRinging  = 2'd2,
    StSnoozing = 2'd3
  } state_e;

  localparam logic [3:0] SnoozeLoad = 4'(SNOOZE_MIN);
  localparam logic [3:0] RingLast   = 4'(RING_MIN - 1);
  localparam logic [2:0] SnoozeMax  = 3'(MAX_SNOOZE);

  state_e     r_state,        w_state_d;
  logic       r_sound,        w_sound_d;
  logic [2:0] r_snoozes_left, w_snoozes_left_d;
  logic [3:0] r_snooze_cnt,   w_snooze_cnt_d;
  logic [3:0] r_ring_cnt,     w_ring_cnt_d;
  logic       r_match;
  logic       w_match;
  logic       w_trigger;

  assign w_match = (i_cur_min == i_alarm_min) && (i_cur_hr == i_alarm_hr) &&
                   (i_cur_pm == i_alarm_pm);
  // Rising edge only, so arming or dismissing inside the alarm minute never fires.
  assign w_trigger = w_match && !r_match;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= StIdle;
      r_sound        <= 1'b0;
      r_snoozes_left <= SnoozeMax;
      r_snooze_cnt   <= 4'd0;
      r_ring_cnt     <= 4'd0;
      r_match        <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_sound        <= w_sound_d;
      r_snoozes_left <= w_snoozes_left_d;
      r_snooze_cnt   <= w_snooze_cnt_d;
      r_ring_cnt     <= w_ring_cnt_d;
      r_match        <= w_match;
    end
  end

  always_comb begin
    w_state_d        = r_state;
    w_snoozes_left_d = r_snoozes_left;
    w_snooze_cnt_d   = r_snooze_cnt;
    w_ring_cnt_d     = r_ring_cnt;
    if (!i_alarm_en) begin
      w_state_d        = StIdle;
      w_snoozes_left_d = SnoozeMax;
      w_snooze_cnt_d   = 4'd0;
      w_ring_cnt_d     = 4'd0;
    end else begin
      unique case (r_state)
        StIdle: begin
          w_state_d = StArmed;
        end
        StArmed: begin
          if (w_trigger) begin
            w_state_d    = StRinging;
            w_ring_cnt_d = 4'd0;
          end
        end
        StRinging: begin
          if (i_dismiss) begin
            w_state_d        = StArmed;
            w_snoozes_left_d = SnoozeMax;
            w_ring_cnt_d     = 4'd0;
          end else if (i_snooze && (r_snoozes_left != 3'd0)) begin
            // A tick in the same cycle is dropped; the snooze period starts full.
            w_state_d        = StSnoozing;
            w_snooze_cnt_d   = SnoozeLoad;
            w_snoozes_left_d = r_snoozes_left - 3'd1;
          end else if (i_min_tick) begin
            if (r_ring_cnt == RingLast) begin
              w_state_d        = StArmed;
              w_snoozes_left_d = SnoozeMax;
              w_ring_cnt_d     = 4'd0;
            end else begin
              w_ring_cnt_d = r_ring_cnt + 4'd1;
            end
          end
        end
        StSnoozing: begin
          if (i_dismiss) begin
            w_state_d        = StArmed;
            w_snoozes_left_d = SnoozeMax;
            w_snooze_cnt_d   = 4'd0;
          end else if (i_min_tick) begin
            if (r_snooze_cnt == 4'd1) begin
              w_state_d      = StRinging;
              w_ring_cnt_d   = 4'd0;
              w_snooze_cnt_d = 4'd0;
            end else begin
              w_snooze_cnt_d = r_snooze_cnt - 4'd1;
            end
          end
        end
        default: begin
          w_state_d = StIdle;
        end
      endcase
    end
  end

  always_comb begin
    w_sound_d      = (w_state_d == StRinging);
    o_state        = r_state;
    o_alarm_sound  = r_sound;
    o_snoozes_left = r_snoozes_left;
  end

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer: alarm set to 10:00am, default parameters.
module tb_alarm_sequencer;

  logic       clk;
  logic       rst;
  logic       min_tick;
  logic [5:0] cur_min;
  logic [3:0] cur_hr;
  logic       cur_pm;
  logic [5:0] alarm_min;
  logic [3:0] alarm_hr;
  logic       alarm_pm;
  logic       alarm_en;
  logic       snooze;
  logic       dismiss;
  logic       alarm_sound;
  logic [1:0] state;
  logic [2:0] snoozes_left;

  int n_checks;
  int n_pass;

  alarm_sequencer #(
    .SNOOZE_MIN(9),
    .MAX_SNOOZE(3),
    .RING_MIN  (10)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_min_tick    (min_tick),
    .i_cur_min     (cur_min),
    .i_cur_hr      (cur_hr),
    .i_cur_pm      (cur_pm),
    .i_alarm_min   (alarm_min),
    .i_alarm_hr    (alarm_hr),
    .i_alarm_pm    (alarm_pm),
    .i_alarm_en    (alarm_en),
    .i_snooze      (snooze),
    .i_dismiss     (dismiss),
    .o_alarm_sound (alarm_sound),
    .o_state       (state),
    .o_snoozes_left(snoozes_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after a negedge; outputs are sampled at the next negedge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic tick_at(input logic [3:0] h, input logic [5:0] m);
    cur_hr = h; cur_min = m; cur_pm = 1'b0; min_tick = 1'b1;
    cyc();
    min_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      min_tick = 1'b1;
      cyc();
      min_tick = 1'b0;
    end
  endtask

  task automatic pulse_snooze();
    snooze = 1'b1;
    cyc();
    snooze = 1'b0;
  endtask

  task automatic pulse_dismiss();
    dismiss = 1'b1;
    cyc();
    dismiss = 1'b0;
  endtask

  // Produce a fresh 10:00am match edge from an armed state.
  task automatic ring_up();
    tick_at(4'd9, 6'd59);
    tick_at(4'd10, 6'd0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc();
    n_checks++; if (state !== 2'd0) $display("FAIL reset_state got %0d want 0", state); else n_pass++;
    n_checks++; if (alarm_sound !== 1'b0) $display("FAIL reset_sound got %0b want 0", alarm_sound); else n_pass++;
    n_checks++; if (snoozes_left !== 3'd3) $display("FAIL reset_snoozes got %0d want 3", snoozes_left); else n_pass++;
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_basic_fire();
    cur_hr = 4'd9; cur_min = 6'd58; cur_pm = 1'b0;
    alarm_en = 1'b1;
    cyc();
    n_checks++; if (state !== 2'd1) $display("FAIL fire_armed got %0d want 1", state); else n_pass++;
    tick_at(4'd9, 6'd59);
    n_checks++; if (state !== 2'd1) $display("FAIL fire_pre_match got %0d want 1", state); else n_pass++;
    tick_at(4'd10, 6'd0);
    n_checks++; if (state !== 2'd2) $display("FAIL fire_ringing got %0d want 2", state); else n_pass++;
    n_checks++; if (alarm_sound !== 1'b1) $display("FAIL fire_sound got %0b want 1", alarm_sound); else n_pass++;
    pulse_dismiss();
    n_checks++; if (state !== 2'd1) $display("FAIL fire_dismiss got %0d want 1", state); else n_pass++;
    n_checks++; if (alarm_sound !== 1'b0) $display("FAIL fire_dismiss_sound got %0b want 0", alarm_sound); else n_pass++;
    cyc(); cyc(); cyc();
    n_checks++; if (state !== 2'd1) $display("FAIL fire_no_retrigger got %0d want 1", state); else n_pass++;
  endtask

  task automatic test_snooze_cycle();
    ring_up();
    n_checks++; if (state !== 2'd2) $display("FAIL snz_ring got %0d want 2", state); else n_pass++;
    for (int r = 0; r < 3; r++) begin
      pulse_snooze();
      n_checks++; if (state !== 2'd3) $display("FAIL snz_state[%0d] got %0d want 3", r, state); else n_pass++;
      n_checks++; if (alarm_sound !== 1'b0) $display("FAIL snz_sound[%0d] got %0b want 0", r, alarm_sound); else n_pass++;
      n_checks++; if (snoozes_left !== 3'(2 - r)) $display("FAIL snz_left[%0d] got %0d want %0d", r, snoozes_left, 2 - r); else n_pass++;
      pulse_snooze();
      n_checks++; if (snoozes_left !== 3'(2 - r)) $display("FAIL snz_ignored[%0d] got %0d want %0d", r, snoozes_left, 2 - r); else n_pass++;
      ticks(8);
      n_checks++; if (state !== 2'd3) $display("FAIL snz_8ticks[%0d] got %0d want 3", r, state); else n_pass++;
      ticks(1);
      n_checks++; if (state !== 2'd2) $display("FAIL snz_9ticks[%0d] got %0d want 2", r, state); else n_pass++;
      n_checks++; if (alarm_sound !== 1'b1) $display("FAIL snz_resound[%0d] got %0b want 1", r, alarm_sound); else n_pass++;
    end
    pulse_snooze();
    n_checks++; if (state !== 2'd2) $display("FAIL snz_limit_state got %0d want 2", state); else n_pass++;
    n_checks++; if (snoozes_left !== 3'd0) $display("FAIL snz_limit_left got %0d want 0", snoozes_left); else n_pass++;
    pulse_dismiss();
    n_checks++; if (state !== 2'd1) $display("FAIL snz_dismiss got %0d want 1", state); else n_pass++;
    n_checks++; if (snoozes_left !== 3'd3) $display("FAIL snz_refill got %0d want 3", snoozes_left); else n_pass++;
  endtask

  task automatic test_timeout();
    ring_up();
    n_checks++; if (state !== 2'd2) $display("FAIL to_ring got %0d want 2", state); else n_pass++;
    pulse_snooze();
    ticks(9);
    n_checks++; if (snoozes_left !== 3'd2) $display("FAIL to_used got %0d want 2", snoozes_left); else n_pass++;
    ticks(9);
    n_checks++; if (state !== 2'd2) $display("FAIL to_9ticks got %0d want 2", state); else n_pass++;
    ticks(1);
    n_checks++; if (state !== 2'd1) $display("FAIL to_expired got %0d want 1", state); else n_pass++;
    n_checks++; if (alarm_sound !== 1'b0) $display("FAIL to_sound got %0b want 0", alarm_sound); else n_pass++;
    n_checks++; if (snoozes_left !== 3'd3) $display("FAIL to_refill got %0d want 3", snoozes_left); else n_pass++;
    cyc(); cyc();
    n_checks++; if (state !== 2'd1) $display("FAIL to_hold got %0d want 1", state); else n_pass++;
    tick_at(4'd10, 6'd1);
    ring_up();
    n_checks++; if (state !== 2'd2) $display("FAIL to_next_day got %0d want 2", state); else n_pass++;
    pulse_dismiss();
  endtask

  task automatic test_priority();
    ring_up();
    snooze = 1'b1; dismiss = 1'b1;
    cyc();
    snooze = 1'b0; dismiss = 1'b0;
    n_checks++; if (state !== 2'd1) $display("FAIL pri_snz_dis got %0d want 1", state); else n_pass++;
    n_checks++; if (snoozes_left !== 3'd3) $display("FAIL pri_snz_dis_left got %0d want 3", snoozes_left); else n_pass++;
    ring_up();
    snooze = 1'b1; min_tick = 1'b1;
    cyc();
    snooze = 1'b0; min_tick = 1'b0;
    n_checks++; if (state !== 2'd3) $display("FAIL pri_snz_tick got %0d want 3", state); else n_pass++;
    n_checks++; if (snoozes_left !== 3'd2) $display("FAIL pri_snz_tick_left got %0d want 2", snoozes_left); else n_pass++;
    ticks(8);
    n_checks++; if (state !== 2'd3) $display("FAIL pri_cnt_full got %0d want 3", state); else n_pass++;
    dismiss = 1'b1; min_tick = 1'b1;
    cyc();
    dismiss = 1'b0; min_tick = 1'b0;
    n_checks++; if (state !== 2'd1) $display("FAIL pri_dis_tick got %0d want 1", state); else n_pass++;
    n_checks++; if (alarm_sound !== 1'b0) $display("FAIL pri_dis_tick_sound got %0b want 0", alarm_sound); else n_pass++;
  endtask

  task automatic test_enable_in_match();
    alarm_en = 1'b0;
    cyc();
    n_checks++; if (state !== 2'd0) $display("FAIL en_off got %0d want 0", state); else n_pass++;
    cur_hr = 4'd10; cur_min = 6'd0; cur_pm = 1'b0;
    cyc();
    alarm_en = 1'b1;
    cyc();
    n_checks++; if (state !== 2'd1) $display("FAIL en_armed got %0d want 1", state); else n_pass++;
    cyc(); cyc(); cyc();
    n_checks++; if (state !== 2'd1) $display("FAIL en_no_fire got %0d want 1", state); else n_pass++;
    ring_up();
    pulse_snooze();
    n_checks++; if (state !== 2'd3) $display("FAIL en_snoozing got %0d want 3", state); else n_pass++;
    alarm_en = 1'b0;
    cyc();
    n_checks++; if (state !== 2'd0) $display("FAIL en_drop got %0d want 0", state); else n_pass++;
    n_checks++; if (snoozes_left !== 3'd3) $display("FAIL en_drop_left got %0d want 3", snoozes_left); else n_pass++;
    alarm_en = 1'b1;
    cyc();
    ticks(9);
    n_checks++; if (state !== 2'd1) $display("FAIL en_cnt_cleared got %0d want 1", state); else n_pass++;
  endtask

  task automatic test_reset_mid_ring();
    ring_up();
    n_checks++; if (alarm_sound !== 1'b1) $display("FAIL rmr_ringing got %0b want 1", alarm_sound); else n_pass++;
    pulse_snooze();
    ticks(9);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (state !== 2'd0) $display("FAIL rmr_state got %0d want 0", state); else n_pass++;
    n_checks++; if (alarm_sound !== 1'b0) $display("FAIL rmr_sound got %0b want 0", alarm_sound); else n_pass++;
    n_checks++; if (snoozes_left !== 3'd3) $display("FAIL rmr_left got %0d want 3", snoozes_left); else n_pass++;
    cyc();
    rst = 1'b0;
    cyc(); cyc(); cyc();
    n_checks++; if (state !== 2'd1) $display("FAIL rmr_rearm got %0d want 1", state); else n_pass++;
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst = 1'b1; min_tick = 1'b0; snooze = 1'b0; dismiss = 1'b0; alarm_en = 1'b0;
    cur_hr = 4'd9; cur_min = 6'd58; cur_pm = 1'b0;
    alarm_hr = 4'd10; alarm_min = 6'd0; alarm_pm = 1'b0;
    test_reset();
    test_basic_fire();
    test_snooze_cycle();
    test_timeout();
    test_priority();
    test_enable_in_match();
    test_reset_mid_ring();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alarm_sequencer.md
Name: alarm_sequencer

Overview:
- Controls alarm sequencing for the 12-hour minute/hour/pm timekeeper.
- Compares the live time against a programmed alarm time and drives the sounder.
- Manages the snooze cycle, a snooze limit, dismiss, and a ring auto-timeout.
- Sits beside the timekeeper: reads its time outputs and a one-cycle minute-advance tick; drives the alarm sound line.

Parameters:
- SNOOZE_MIN, 9: minutes of silence per snooze (1..15).
- MAX_SNOOZE, 3: snoozes allowed per alarm event (1..7).
- RING_MIN, 10: minutes of unattended ringing before auto-stop (1..15).

Ports:
- clk  input  1  system clock, all state on posedge.
- rst  input  1  asynchronous active-high reset.
- min_tick  input  1  one-cycle pulse; the time advanced one minute this cycle.
- cur_min  input  6  current minutes, 0..59.
- cur_hr  input  4  current hours, 1..12.
- cur_pm  input  1  current pm flag.
- alarm_min  input  6  alarm minutes.
- alarm_hr  input  4  alarm hours.
- alarm_pm  input  1  alarm pm flag.
- alarm_en  input  1  level; alarm armed while high.
- snooze  input  1  one-cycle pulse, snooze request.
- dismiss  input  1  one-cycle pulse, stop the alarm event.
- alarm_sound  output  1  sounder drive.
- state  output  2  IDLE=0, ARMED=1, RINGING=2, SNOOZING=3.
- snoozes_left  output  3  remaining snoozes in the current event.

Behaviour:
- Reset: state=IDLE, alarm_sound=0, snoozes_left=MAX_SNOOZE, match_q=0, snooze_cnt=0, ring_cnt=0. Reset is asynchronous and can occur mid-ring; outputs clear immediately.
- Outputs are registered. alarm_sound is 1 exactly when state==RINGING and is updated in the same register write as state.
- match = (cur_min==alarm_min) && (cur_hr==alarm_hr) && (cur_pm==alarm_pm), evaluated combinationally.
- match_q <= match every cycle in all states.
- trigger = match && !match_q (rising edge only).
- Enabling the alarm inside the matching minute does not fire. Dismissing inside the matching minute does not re-fire.
- Event priority, highest first: !alarm_en > dismiss > snooze > timeout/countdown > trigger.
- IDLE: alarm_en=1 -> ARMED next cycle.
- Any state with alarm_en=0 -> IDLE. This clears snoozes_left to MAX_SNOOZE and zeroes both counters.
- ARMED: trigger -> RINGING, ring_cnt=0. dismiss and snooze are ignored.
- RINGING:
  - dismiss -> ARMED, snoozes_left=MAX_SNOOZE.
  - snooze with snoozes_left>0 -> SNOOZING, snooze_cnt=SNOOZE_MIN, snoozes_left-1.
  - snooze with snoozes_left==0 is ignored; the block stays RINGING.
  - Otherwise each min_tick increments ring_cnt. When ring_cnt reaches RING_MIN-1 and min_tick is high -> ARMED, snoozes_left=MAX_SNOOZE.
  - trigger is ignored.
- SNOOZING:
  - dismiss -> ARMED, snoozes_left=MAX_SNOOZE.
  - snooze pulses are ignored.
  - Each min_tick decrements snooze_cnt. min_tick with snooze_cnt==1 -> RINGING, ring_cnt=0.
- Snooze and min_tick in the same RINGING cycle: snooze wins; the tick is dropped and snooze_cnt loads SNOOZE_MIN.
- Dismiss and min_tick in the same cycle: dismiss wins.
- Latency: a qualifying input in cycle N gives the new state/alarm_sound after posedge N (visible cycle N+1).
- Counter widths: 4-bit snooze_cnt and ring_cnt, no wrap. Out-of-range time inputs simply never match.

Test Plan:
- Reset mid-ring: state=RINGING, assert rst between clock edges -> alarm_sound=0 and state=0 immediately, with no clock edge needed; snoozes_left=3.
- Basic fire: alarm_en=1, alarm 10:00am; walk time 9:58am->10:00am with min_tick -> state 1 then 2 on the cycle after 10:00 appears; alarm_sound=1. Hold 10:00 for 3 cycles -> no retrigger after dismiss.
- Snooze cycle: ringing; pulse snooze -> state=3, snoozes_left=2, alarm_sound=0. 9 min_ticks -> state=2 after the 9th. Repeat 3 times. 4th snooze -> stays 2, snoozes_left=0.
- Timeout: ringing with no input; 10 min_ticks -> state=1, alarm_sound=0, snoozes_left=3. Next day's 10:00am match edge -> rings again.
- Priority: while ringing, pulse snooze+dismiss in the same cycle -> state=1, snoozes_left=3. Snooze+min_tick in the same cycle -> state=3, snooze_cnt=9.
- Enable inside the match minute: time=10:00am, raise alarm_en -> state 1, never 2 until the next match edge. Drop alarm_en while in SNOOZING -> state=0 next cycle.
